// File: rtl/block_memory_core_if.sv
// Daisy-chained register bus bundle: address, write data, read data,
// direction and strobe travelling from core to core.
interface block_memory_core_if #(
    parameter int BUS_WIDTH = 16
) ();
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
    logic [BUS_WIDTH-1:0] rdata;
    logic                 rw;
    logic                 valid;

    // Driving side of a bus segment (a core's downstream output)
    modport master (
        output addr,
        output wdata,
        output rdata,
        output rw,
        output valid
    );

    // Receiving side of a bus segment (a core's upstream input)
    modport slave (
        input addr,
        input wdata,
        input rdata,
        input rw,
        input valid
    );
endinterface

// File: rtl/block_memory_core.sv
// Bus-attached DATA_WIDTH x DEPTH block memory. One port is reached over the
// daisy-chained register bus in BUS_WIDTH chunks (optionally atomic through
// shadow registers), the other is a native-width user port. The bus is
// forwarded with a fixed LATENCY; only in-range reads replace rdata.
module block_memory_core #(
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 256,
    parameter int          BUS_WIDTH  = 16,
    parameter int          LATENCY    = 4,
    parameter int          ATOMIC     = 1,
    parameter int          USER_WRITE = 1,
    localparam int         ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    block_memory_core_if.slave        up_if,
    block_memory_core_if.master       dn_if,
    input  logic [ADDR_WIDTH-1:0]     user_addr,
    input  logic [DATA_WIDTH-1:0]     user_din,
    input  logic                      user_we,
    output logic [DATA_WIDTH-1:0]     user_dout,
    output logic                      collision_o
);

    localparam int N_CHUNKS = (DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int PAD_W    = N_CHUNKS * BUS_WIDTH;
    localparam int CHUNK_W  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    localparam logic [63:0]           BASE_L    = 64'(BASE_ADDR);
    localparam logic [63:0]           LAST_L    = 64'(BASE_ADDR) + 64'(DEPTH) * 64'(N_CHUNKS) - 64'd1;
    localparam logic [CHUNK_W-1:0]    TOP_CHUNK = CHUNK_W'(N_CHUNKS - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic                  ATOMIC_ON = (ATOMIC != 0) && (N_CHUNKS > 1);

    // Zero-extend a memory word to a whole number of bus chunks, so the
    // unused top bits of the last chunk read back as zero.
    function automatic logic [PAD_W-1:0] pad_word(input logic [DATA_WIDTH-1:0] w);
        logic [PAD_W-1:0] p;
        p = '0;
        p[DATA_WIDTH-1:0] = w;
        return p;
    endfunction

    // Select bus chunk k of a padded word.
    function automatic logic [BUS_WIDTH-1:0] get_chunk(input logic [PAD_W-1:0] p,
                                                       input logic [CHUNK_W-1:0] k);
        return p[k*BUS_WIDTH +: BUS_WIDTH];
    endfunction

    // Storage: not reset, contents survive rst_n.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Bus decode and write shaping
    logic [63:0]           addr_ext_s;
    logic [63:0]           off_s;
    logic                  in_range_s;
    logic [ADDR_WIDTH-1:0] word_s;
    logic [CHUNK_W-1:0]    chunk_s;
    logic                  rd_hit_s;
    logic                  bus_we_s;
    logic                  shadow_ld_s;
    logic [PAD_W-1:0]      pad_mask_s;
    logic [PAD_W-1:0]      pad_data_s;
    logic [DATA_WIDTH-1:0] bus_wmask_s;
    logic [DATA_WIDTH-1:0] bus_wdata_s;
    logic                  user_ok_s;
    logic                  user_we_s;
    logic [ADDR_WIDTH-1:0] user_idx_s;
    logic                  coll_s;

    // Shadow registers
    logic [PAD_W-1:0]      wr_shadow_q;
    logic [DATA_WIDTH-1:0] rd_shadow_q;
    logic [ADDR_WIDTH-1:0] rd_tag_q;
    logic                  rd_ok_q;

    // User side registers
    logic [DATA_WIDTH-1:0] user_dout_q;
    logic                  collision_q;

    // Stage 1: captured bus fields plus everything needed to form rdata
    logic [BUS_WIDTH-1:0]  s1_addr_q;
    logic [BUS_WIDTH-1:0]  s1_wdata_q;
    logic [BUS_WIDTH-1:0]  s1_rdata_q;
    logic                  s1_rw_q;
    logic                  s1_valid_q;
    logic                  s1_hit_q;
    logic                  s1_use_sh_q;
    logic [CHUNK_W-1:0]    s1_chunk_q;
    logic [BUS_WIDTH-1:0]  s1_sh_chunk_q;
    logic [DATA_WIDTH-1:0] s1_mem_q;
    logic [BUS_WIDTH-1:0]  s2_rdata_d;

    // Stages 2..LATENCY: plain delay line, last stage drives the outputs
    logic [BUS_WIDTH-1:0]  pipe_addr_q  [2:LATENCY];
    logic [BUS_WIDTH-1:0]  pipe_wdata_q [2:LATENCY];
    logic [BUS_WIDTH-1:0]  pipe_rdata_q [2:LATENCY];
    logic                  pipe_rw_q    [2:LATENCY];
    logic                  pipe_valid_q [2:LATENCY];

    // Decode the upstream address into word/chunk and range flag
    always_comb begin
        addr_ext_s = 64'(up_if.addr);
        in_range_s = (addr_ext_s >= BASE_L) && (addr_ext_s <= LAST_L);
        off_s      = addr_ext_s - BASE_L;
        if (in_range_s) begin
            word_s  = ADDR_WIDTH'(off_s / 64'(N_CHUNKS));
            chunk_s = CHUNK_W'(off_s % 64'(N_CHUNKS));
        end else begin
            word_s  = '0;
            chunk_s = '0;
        end
        rd_hit_s = up_if.valid && !up_if.rw && in_range_s;
    end

    // Form the bus write: shadow load, atomic commit or direct chunk write
    always_comb begin
        bus_we_s    = 1'b0;
        shadow_ld_s = 1'b0;
        pad_mask_s  = '0;
        pad_data_s  = '0;
        if (up_if.valid && up_if.rw && in_range_s) begin
            if (ATOMIC_ON) begin
                if (chunk_s == TOP_CHUNK) begin
                    bus_we_s   = 1'b1;
                    pad_mask_s = {PAD_W{1'b1}};
                    pad_data_s = wr_shadow_q;
                    pad_data_s[(N_CHUNKS-1)*BUS_WIDTH +: BUS_WIDTH] = up_if.wdata;
                end else begin
                    shadow_ld_s = 1'b1;
                end
            end else begin
                bus_we_s = 1'b1;
                pad_mask_s[chunk_s*BUS_WIDTH +: BUS_WIDTH] = {BUS_WIDTH{1'b1}};
                pad_data_s[chunk_s*BUS_WIDTH +: BUS_WIDTH] = up_if.wdata;
            end
        end else begin
            bus_we_s    = 1'b0;
            shadow_ld_s = 1'b0;
        end
        // Bits above DATA_WIDTH in the top chunk are dropped here
        bus_wmask_s = DATA_WIDTH'(pad_mask_s);
        bus_wdata_s = DATA_WIDTH'(pad_data_s);
    end

    // User port qualification and user/bus collision on the same word
    always_comb begin
        user_ok_s = ({1'b0, user_addr} < DEPTH_L);
        if (user_ok_s) begin
            user_idx_s = user_addr;
        end else begin
            user_idx_s = '0;
        end
        user_we_s = user_we && (USER_WRITE != 0) && user_ok_s;
        coll_s    = bus_we_s && user_we_s && (word_s == user_addr);
    end

    // Memory writes: user write wins a same-word collision outright
    always_ff @(posedge clk) begin
        if (bus_we_s && !coll_s) begin
            mem_q[word_s] <= (mem_q[word_s] & ~bus_wmask_s) | (bus_wdata_s & bus_wmask_s);
        end
        if (user_we_s) begin
            mem_q[user_addr] <= user_din;
        end
    end

    // Shadows, user read data, collision pulse and stage-1 capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_shadow_q   <= '0;
            rd_shadow_q   <= '0;
            rd_tag_q      <= '0;
            rd_ok_q       <= 1'b0;
            user_dout_q   <= '0;
            collision_q   <= 1'b0;
            s1_addr_q     <= '0;
            s1_wdata_q    <= '0;
            s1_rdata_q    <= '0;
            s1_rw_q       <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_hit_q      <= 1'b0;
            s1_use_sh_q   <= 1'b0;
            s1_chunk_q    <= '0;
            s1_sh_chunk_q <= '0;
            s1_mem_q      <= '0;
        end else begin
            user_dout_q <= mem_q[user_idx_s];
            collision_q <= coll_s;
            if (shadow_ld_s) begin
                wr_shadow_q[chunk_s*BUS_WIDTH +: BUS_WIDTH] <= up_if.wdata;
            end
            // Chunk-0 read snapshots the whole word for the later chunks
            if (rd_hit_s && ATOMIC_ON && (chunk_s == '0)) begin
                rd_shadow_q <= mem_q[word_s];
                rd_tag_q    <= word_s;
                rd_ok_q     <= 1'b1;
            end
            s1_addr_q     <= up_if.addr;
            s1_wdata_q    <= up_if.wdata;
            s1_rdata_q    <= up_if.rdata;
            s1_rw_q       <= up_if.rw;
            s1_valid_q    <= up_if.valid;
            s1_hit_q      <= rd_hit_s;
            s1_use_sh_q   <= ATOMIC_ON && (chunk_s != '0) && rd_ok_q && (rd_tag_q == word_s);
            s1_chunk_q    <= chunk_s;
            s1_sh_chunk_q <= get_chunk(pad_word(rd_shadow_q), chunk_s);
            s1_mem_q      <= mem_q[word_s];
        end
    end

    // Replace rdata for in-range reads with the shadow or memory chunk
    always_comb begin
        if (s1_hit_q) begin
            if (s1_use_sh_q) begin
                s2_rdata_d = s1_sh_chunk_q;
            end else begin
                s2_rdata_d = get_chunk(pad_word(s1_mem_q), s1_chunk_q);
            end
        end else begin
            s2_rdata_d = s1_rdata_q;
        end
    end

    // Remaining pass-through delay; reset drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 2; i <= LATENCY; i++) begin
                pipe_addr_q[i]  <= '0;
                pipe_wdata_q[i] <= '0;
                pipe_rdata_q[i] <= '0;
                pipe_rw_q[i]    <= 1'b0;
                pipe_valid_q[i] <= 1'b0;
            end
        end else begin
            pipe_addr_q[2]  <= s1_addr_q;
            pipe_wdata_q[2] <= s1_wdata_q;
            pipe_rdata_q[2] <= s2_rdata_d;
            pipe_rw_q[2]    <= s1_rw_q;
            pipe_valid_q[2] <= s1_valid_q;
            for (int i = 3; i <= LATENCY; i++) begin
                pipe_addr_q[i]  <= pipe_addr_q[i-1];
                pipe_wdata_q[i] <= pipe_wdata_q[i-1];
                pipe_rdata_q[i] <= pipe_rdata_q[i-1];
                pipe_rw_q[i]    <= pipe_rw_q[i-1];
                pipe_valid_q[i] <= pipe_valid_q[i-1];
            end
        end
    end

    assign dn_if.addr   = pipe_addr_q[LATENCY];
    assign dn_if.wdata  = pipe_wdata_q[LATENCY];
    assign dn_if.rdata  = pipe_rdata_q[LATENCY];
    assign dn_if.rw     = pipe_rw_q[LATENCY];
    assign dn_if.valid  = pipe_valid_q[LATENCY];
    assign user_dout    = user_dout_q;
    assign collision_o  = collision_q;

endmodule

// File: tb/tb_block_memory_core.sv
// Bench for block_memory_core: an atomic 32-bit instance driven by random
// traffic against a word-level reference model, plus a 20-bit direct-access
// instance exercised with directed transactions.
module tb_block_memory_core;

    localparam int BW    = 16;
    localparam int DW1   = 32;
    localparam int DEP1  = 16;
    localparam int LAT1  = 4;
    localparam int BASE1 = 32'h100;
    localparam int N1    = 2;
    localparam int DW2   = 20;
    localparam int DEP2  = 8;
    localparam int LAT2  = 3;
    localparam int BASE2 = 32'h40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    block_memory_core_if #(.BUS_WIDTH(BW)) up1 ();
    block_memory_core_if #(.BUS_WIDTH(BW)) dn1 ();
    block_memory_core_if #(.BUS_WIDTH(BW)) up2 ();
    block_memory_core_if #(.BUS_WIDTH(BW)) dn2 ();

    logic [3:0]     u1_addr;
    logic [DW1-1:0] u1_din;
    logic           u1_we;
    logic [DW1-1:0] u1_dout;
    logic           coll1;
    logic [2:0]     u2_addr;
    logic [DW2-1:0] u2_din;
    logic           u2_we;
    logic [DW2-1:0] u2_dout;
    logic           coll2;

    block_memory_core #(.BASE_ADDR(BASE1), .DATA_WIDTH(DW1), .DEPTH(DEP1), .BUS_WIDTH(BW),
                        .LATENCY(LAT1), .ATOMIC(1), .USER_WRITE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .up_if(up1), .dn_if(dn1),
        .user_addr(u1_addr), .user_din(u1_din), .user_we(u1_we),
        .user_dout(u1_dout), .collision_o(coll1));

    block_memory_core #(.BASE_ADDR(BASE2), .DATA_WIDTH(DW2), .DEPTH(DEP2), .BUS_WIDTH(BW),
                        .LATENCY(LAT2), .ATOMIC(0), .USER_WRITE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .up_if(up2), .dn_if(dn2),
        .user_addr(u2_addr), .user_din(u2_din), .user_we(u2_we),
        .user_dout(u2_dout), .collision_o(coll2));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state for instance 1
    logic [31:0] m_mem [DEP1];
    logic [15:0] m_wsh;
    logic [31:0] m_rsh;
    int          m_tag;
    bit          m_ok;
    logic [49:0] exp_q [$];
    logic [31:0] exp_ud;
    bit          exp_coll;
    bit          chk_ud;
    int          cyc;
    logic [15:0] hist_rd  [int];
    bit          hist_v   [int];
    logic [15:0] hist2_rd [int];
    bit          hist2_v  [int];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < LAT1 - 1; i++) exp_q.push_back(50'd0);
        m_wsh = 16'd0;
        m_rsh = 32'd0;
        m_tag = 0;
        m_ok  = 1'b0;
    endtask

    // Apply the rules of one sampling edge to the model, using current inputs
    task automatic model_edge();
        int a, off, word, chunk;
        bit inr, commit, coll;
        logic [15:0] rv;
        logic [31:0] cdata;
        a      = int'(up1.addr);
        inr    = (a >= BASE1) && (a <= BASE1 + DEP1 * N1 - 1);
        off    = a - BASE1;
        word   = inr ? off / N1 : 0;
        chunk  = inr ? off % N1 : 0;
        rv     = up1.rdata;
        commit = 1'b0;
        cdata  = 32'd0;
        if (up1.valid && inr) begin
            if (!up1.rw) begin
                if (chunk == 0) begin
                    rv    = m_mem[word][15:0];
                    m_rsh = m_mem[word];
                    m_tag = word;
                    m_ok  = 1'b1;
                end else if (m_ok && m_tag == word) begin
                    rv = m_rsh[31:16];
                end else begin
                    rv = m_mem[word][31:16];
                end
            end else begin
                if (chunk == 0) m_wsh = up1.wdata;
                else begin
                    commit = 1'b1;
                    cdata  = {up1.wdata, m_wsh};
                end
            end
        end
        exp_q.push_back({up1.addr, up1.wdata, rv, up1.rw, up1.valid});
        exp_ud   = m_mem[int'(u1_addr)];
        coll     = commit && u1_we && (int'(u1_addr) == word);
        exp_coll = coll;
        if (commit && !coll) m_mem[word] = cdata;
        if (u1_we) m_mem[int'(u1_addr)] = u1_din;
    endtask

    // One clock: model, edge, then compare outputs away from the edge
    task automatic step();
        logic [49:0] e;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        hist_rd[cyc]  = dn1.rdata;
        hist_v[cyc]   = dn1.valid;
        hist2_rd[cyc] = dn2.rdata;
        hist2_v[cyc]  = dn2.valid;
        if (exp_q.size() >= LAT1) begin
            e = exp_q.pop_front();
            check_val("bus_out", {14'd0, dn1.addr, dn1.wdata, dn1.rdata, dn1.rw, dn1.valid}, {14'd0, e});
        end
        if (chk_ud) begin
            check_val("user_dout", 64'(u1_dout), 64'(exp_ud));
            check_val("collision", 64'(coll1), 64'(exp_coll));
        end
    endtask

    task automatic bus1(input int a, input logic [15:0] wd, input logic rw, input logic [15:0] rd);
        up1.addr  = 16'(a);
        up1.wdata = wd;
        up1.rdata = rd;
        up1.rw    = rw;
        up1.valid = 1'b1;
    endtask

    task automatic idle1();
        up1.addr  = 16'd0;
        up1.wdata = 16'd0;
        up1.rdata = 16'd0;
        up1.rw    = 1'b0;
        up1.valid = 1'b0;
    endtask

    task automatic bus2(input int a, input logic [15:0] wd, input logic rw, input logic [15:0] rd);
        up2.addr  = 16'(a);
        up2.wdata = wd;
        up2.rdata = rd;
        up2.rw    = rw;
        up2.valid = 1'b1;
    endtask

    task automatic idle2();
        up2.addr  = 16'd0;
        up2.wdata = 16'd0;
        up2.rdata = 16'd0;
        up2.rw    = 1'b0;
        up2.valid = 1'b0;
    endtask

    initial begin
        int n_a, n_b, n_c, n_d, n_e, n_f, n_g, a, w;
        cyc    = 0;
        chk_ud = 1'b0;
        rst_n  = 1'b0;
        idle1();
        idle2();
        u1_addr = 4'd0; u1_din = 32'd0; u1_we = 1'b0;
        u2_addr = 3'd0; u2_din = 20'd0; u2_we = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(dn1.valid), 64'd0);
        check_val("rst_bus", {14'd0, dn1.addr, dn1.wdata, dn1.rdata, dn1.rw, dn1.valid}, 64'd0);
        check_val("rst_user_dout", 64'(u1_dout), 64'd0);
        check_val("rst_collision", 64'(coll1), 64'd0);
        check_val("rst_valid2", 64'(dn2.valid), 64'd0);
        #2 rst_n = 1'b1;

        // Give every word a known value through the user ports
        for (int i = 0; i < DEP1; i++) begin
            u1_addr = 4'(i); u1_din = $urandom; u1_we = 1'b1;
            u2_addr = 3'(i % DEP2); u2_din = 20'($urandom); u2_we = 1'b1;
            step();
        end
        u1_we = 1'b0; u2_we = 1'b0;
        chk_ud = 1'b1;

        // Atomic write: word 2 only changes on the top-chunk commit
        u1_addr = 4'd2;
        bus1(32'h104, 16'hBEEF, 1'b1, 16'd0); step();
        bus1(32'h105, 16'hDEAD, 1'b1, 16'd0); step();
        idle1(); step();
        check_val("atomic_word", 64'(u1_dout), 64'hDEADBEEF);

        // Shadowed read survives a user write between the chunks
        n_a = cyc + 1;
        bus1(32'h104, 16'd0, 1'b0, 16'h1111); step();
        idle1(); u1_we = 1'b1; u1_din = 32'h12345678; step();
        u1_we = 1'b0;
        n_b = cyc + 1;
        bus1(32'h105, 16'd0, 1'b0, 16'h2222); step();
        idle1();
        repeat (LAT1) step();
        check_val("rd_chunk0", 64'(hist_rd[n_a + LAT1 - 1]), 64'hBEEF);
        check_val("rd_latency", 64'(hist_v[n_a + LAT1 - 1]), 64'd1);
        check_val("rd_not_early", 64'(hist_v[n_a + LAT1 - 2]), 64'd0);
        check_val("rd_shadow", 64'(hist_rd[n_b + LAT1 - 1]), 64'hDEAD);

        // Out of range on both sides pass through; last address is in range
        n_c = cyc + 1;
        bus1(32'hFF, 16'h1234, 1'b0, 16'hA5A5); step();
        n_d = cyc + 1;
        bus1(BASE1 + 2 * DEP1, 16'h4321, 1'b0, 16'hA5A5); step();
        bus1(BASE1 + 2 * DEP1 - 1, 16'h0, 1'b0, 16'hA5A5); step();
        idle1();
        repeat (LAT1) step();
        check_val("oor_low", 64'(hist_rd[n_c + LAT1 - 1]), 64'hA5A5);
        check_val("oor_high", 64'(hist_rd[n_d + LAT1 - 1]), 64'hA5A5);

        // Same-edge bus commit and user write on word 5
        bus1(32'h10A, 16'h1111, 1'b1, 16'd0); step();
        bus1(32'h10B, 16'h2222, 1'b1, 16'd0);
        u1_addr = 4'd5; u1_we = 1'b1; u1_din = 32'hCAFEF00D; step();
        check_val("coll_pulse", 64'(coll1), 64'd1);
        idle1(); u1_we = 1'b0; step();
        check_val("coll_one_cycle", 64'(coll1), 64'd0);
        check_val("coll_user_wins", 64'(u1_dout), 64'hCAFEF00D);

        // Random traffic around the address window
        for (int i = 0; i < 1500; i++) begin
            a = int'($urandom_range(32'hFE, BASE1 + 2 * DEP1 + 1));
            bus1(a, 16'($urandom), 1'($urandom), 16'($urandom));
            up1.valid = ($urandom_range(0, 4) != 0);
            u1_addr = 4'($urandom);
            u1_din  = $urandom;
            u1_we   = ($urandom_range(0, 3) == 0);
            if (a >= BASE1 && a < BASE1 + 2 * DEP1 && $urandom_range(0, 3) == 0) begin
                w = (a - BASE1) / N1;
                u1_addr = 4'(w);
            end
            step();
        end
        idle1(); u1_we = 1'b0;
        repeat (LAT1) step();

        // Reset with three reads in flight
        bus1(32'h100, 16'd0, 1'b0, 16'h0001); step();
        bus1(32'h102, 16'd0, 1'b0, 16'h0002); step();
        bus1(32'h104, 16'd0, 1'b0, 16'h0003); step();
        idle1();
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", 64'(dn1.valid), 64'd0);
        check_val("arst_bus", {14'd0, dn1.addr, dn1.wdata, dn1.rdata, dn1.rw, dn1.valid}, 64'd0);
        check_val("arst_user_dout", 64'(u1_dout), 64'd0);
        model_reset();
        #2 rst_n = 1'b1;
        for (int i = 0; i < LAT1 + 2; i++) begin
            step();
            check_val("no_valid_after_rst", 64'(dn1.valid), 64'd0);
        end
        for (int i = 0; i < DEP1; i++) begin
            u1_addr = 4'(i);
            step();
        end
        step();

        // Direct-access 20-bit instance: partial top chunk
        u2_addr = 3'd3; u2_din = 20'h12345; u2_we = 1'b1; step();
        u2_we = 1'b0;
        bus2(BASE2 + 7, 16'hFFFF, 1'b1, 16'd0); step();
        n_e = cyc + 1;
        bus2(BASE2 + 7, 16'd0, 1'b0, 16'h7777); step();
        n_f = cyc + 1;
        bus2(BASE2 + 6, 16'd0, 1'b0, 16'h7777); step();
        n_g = cyc + 1;
        bus2(32'h30, 16'd0, 1'b0, 16'h5A5A); step();
        idle2();
        repeat (LAT2) step();
        check_val("w20_top_chunk", 64'(hist2_rd[n_e + LAT2 - 1]), 64'h000F);
        check_val("w20_latency", 64'(hist2_v[n_e + LAT2 - 1]), 64'd1);
        check_val("w20_low_chunk", 64'(hist2_rd[n_f + LAT2 - 1]), 64'h2345);
        check_val("w20_oor", 64'(hist2_rd[n_g + LAT2 - 1]), 64'h5A5A);
        check_val("w20_user_top", 64'(u2_dout[19:16]), 64'hF);
        check_val("w20_user_word", 64'(u2_dout), 64'hF2345);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
